pc_stack: RTL and testbench

- Parametrised program counter for the single-cycle CPU core with a hardware return-address stack (RAS).
- Supports sequential increment, absolute jump, signed relative branch, subroutine call (push return address) and return (pop).
- Adds a stall/enable input and stack status flags.
- Sits between the control unit (decoded op strobes) and the instruction memory address input.

---
 rtl/pc_pkg.sv | 14 +
 rtl/pc_stack_if.sv | 18 +
 rtl/pc_stack_ras_lifo.sv | 34 +++
 rtl/pc_stack.sv | 46 ++++
 tb/tb_pc_stack.sv | 110 +++++++++++
 5 files changed

// File: rtl/pc_pkg.sv
// pc_pkg: action codes and pointer-width helper shared by the program counter and its return-address stack
package pc_pkg;
    localparam logic [2:0] PC_INC  = 3'd0;
    localparam logic [2:0] PC_BR   = 3'd1;
    localparam logic [2:0] PC_LD   = 3'd2;
    localparam logic [2:0] PC_CALL = 3'd3;
    localparam logic [2:0] PC_RET  = 3'd4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/pc_stack_if.sv
// pc_stack_if: control-unit strobes into the program counter and address/stack status back out
interface pc_stack_if #(parameter int WIDTH = 8);
    logic             en;
    logic             ld;
    logic             br;
    logic             call;
    logic             ret;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] offset;
    logic [WIDTH-1:0] pc_out;
    logic             stk_full;
    logic             stk_empty;
    logic             stk_err;
    modport master (output en, ld, br, call, ret, addr, offset,
                    input pc_out, stk_full, stk_empty, stk_err);
    modport slave  (input en, ld, br, call, ret, addr, offset,
                    output pc_out, stk_full, stk_empty, stk_err);
endinterface

// File: rtl/pc_stack_ras_lifo.sv
// ras_lifo: return-address LIFO that silently drops pushes when full and pops when empty
module ras_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] sp;
    logic [PTR_W-1:0] top_idx;
    assign full    = sp == PTR_W'(DEPTH);
    assign empty   = sp == '0;
    assign top_idx = sp - 1'b1;
    assign dout    = mem[top_idx[PTR_W-2:0]];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !full) begin
            mem[sp[PTR_W-2:0]] <= din;
            sp <= sp + 1'b1;
        end else if (pop && !empty) begin
            sp <= sp - 1'b1;
        end
    end
endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter with increment/jump/branch/call/return and a sticky overflow/underflow flag
module pc_stack
    import pc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PTR_W = clog2(DEPTH) + 1
) (
    input logic       clk,
    input logic       rst,
    pc_stack_if.slave bus
);
    logic [2:0]       act;
    logic [WIDTH-1:0] pc, pc_inc, nxt, top;
    logic             full, empty, err, fault;
    assign act = bus.ret ? PC_RET : bus.call ? PC_CALL : bus.ld ? PC_LD : bus.br ? PC_BR : PC_INC;
    assign pc_inc = pc + 1'b1;
    // an empty-stack return degrades to a plain increment
    assign nxt = act == PC_RET ? (empty ? pc_inc : top) :
                 (act == PC_CALL || act == PC_LD) ? bus.addr :
                 act == PC_BR ? pc + bus.offset : pc_inc;
    assign fault = (act == PC_CALL && full) || (act == PC_RET && empty);
    ras_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_ras (
        .clk  (clk),
        .rst  (rst),
        .push (bus.en && act == PC_CALL),
        .pop  (bus.en && act == PC_RET),
        .din  (pc_inc),
        .dout (top),
        .full (full),
        .empty(empty)
    );
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= '0;
            err <= 1'b0;
        end else if (bus.en) begin
            pc  <= nxt;
            err <= err | fault;
        end
    end
    assign bus.pc_out    = pc;
    assign bus.stk_full  = full;
    assign bus.stk_empty = empty;
    assign bus.stk_err   = err;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scoreboard bench for pc_stack
module tb_pc_stack;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int total = 0;
    int bad = 0;
    logic [7:0] sb [$];
    pc_stack_if #(.WIDTH(8)) bus ();
    pc_stack #(.WIDTH(8), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkf(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic e, l, b, c, r,
                        input logic [7:0] a, o, exp);
        bus.en = e; bus.ld = l; bus.br = b; bus.call = c; bus.ret = r;
        bus.addr = a; bus.offset = o;
        sb.push_back(exp);
        @(posedge clk);
        #1;
        chk(tag, bus.pc_out, sb.pop_front());
    endtask

    initial begin
        bus.en = 1'b0; bus.ld = 1'b0; bus.br = 1'b0; bus.call = 1'b0; bus.ret = 1'b0;
        bus.addr = '0; bus.offset = '0;
        #12;
        chk("rst_pc", bus.pc_out, 8'h00);
        chkf("rst_empty", bus.stk_empty, 1'b1);
        chkf("rst_full", bus.stk_full, 1'b0);
        chkf("rst_err", bus.stk_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int i = 1; i <= 5; i++) step("inc", 1, 0, 0, 0, 0, 0, 0, 8'(i));
        chkf("inc_empty", bus.stk_empty, 1'b1);
        chkf("inc_err", bus.stk_err, 1'b0);
        bus.call = 1'b1; bus.addr = 8'h77;
        #2 rst = 1'b0;
        #1 chk("async_rst", bus.pc_out, 8'h00);
        @(posedge clk); #1;
        chk("rst_hold", bus.pc_out, 8'h00);
        chkf("rst_hold_empty", bus.stk_empty, 1'b1);
        rst = 1'b1;
        step("ld_fe", 1, 1, 0, 0, 0, 8'hFE, 0, 8'hFE);
        step("wrap0", 1, 0, 0, 0, 0, 0, 0, 8'hFF);
        step("wrap1", 1, 0, 0, 0, 0, 0, 0, 8'h00);
        step("wrap2", 1, 0, 0, 0, 0, 0, 0, 8'h01);
        step("br_neg", 1, 0, 1, 0, 0, 0, 8'hFC, 8'hFD);
        step("br_pos", 1, 0, 1, 0, 0, 0, 8'h05, 8'h02);
        step("br_zero", 1, 0, 1, 0, 0, 0, 8'h00, 8'h02);
        step("ld_10", 1, 1, 0, 0, 0, 8'd10, 0, 8'd10);
        step("call40", 1, 0, 0, 1, 0, 8'd40, 0, 8'd40);
        chkf("call_nonempty", bus.stk_empty, 1'b0);
        step("call80", 1, 0, 0, 1, 0, 8'd80, 0, 8'd80);
        step("ret41", 1, 0, 0, 0, 1, 0, 0, 8'd41);
        step("ret11", 1, 0, 0, 0, 1, 0, 0, 8'd11);
        chkf("nest_empty", bus.stk_empty, 1'b1);
        chkf("nest_err", bus.stk_err, 1'b0);
        step("ld_0", 1, 1, 0, 0, 0, 8'd0, 0, 8'd0);
        for (int i = 1; i <= 4; i++) step("ovf_call", 1, 0, 0, 1, 0, 8'(16 * i), 0, 8'(16 * i));
        chkf("ovf_full4", bus.stk_full, 1'b1);
        chkf("ovf_err4", bus.stk_err, 1'b0);
        step("ovf_call5", 1, 0, 0, 1, 0, 8'd80, 0, 8'd80);
        chkf("ovf_full5", bus.stk_full, 1'b1);
        chkf("ovf_err5", bus.stk_err, 1'b1);
        step("ovf_ret49", 1, 0, 0, 0, 1, 0, 0, 8'd49);
        chkf("ovf_notfull", bus.stk_full, 1'b0);
        step("ovf_ret33", 1, 0, 0, 0, 1, 0, 0, 8'd33);
        step("ovf_ret17", 1, 0, 0, 0, 1, 0, 0, 8'd17);
        step("ovf_ret1", 1, 0, 0, 0, 1, 0, 0, 8'd1);
        chkf("ovf_empty", bus.stk_empty, 1'b1);
        chkf("ovf_err_sticky", bus.stk_err, 1'b1);
        rst = 1'b0;
        #1 chkf("rst_err_clr", bus.stk_err, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        step("ld_20", 1, 1, 0, 0, 0, 8'd20, 0, 8'd20);
        step("udf_ret", 1, 0, 0, 0, 1, 0, 0, 8'd21);
        chkf("udf_err", bus.stk_err, 1'b1);
        chkf("udf_empty", bus.stk_empty, 1'b1);
        step("call_ret", 1, 0, 0, 1, 1, 8'd90, 0, 8'd22);
        chkf("call_ret_nopush", bus.stk_empty, 1'b1);
        step("ld_br", 1, 1, 1, 0, 0, 8'd30, 8'h10, 8'd30);
        step("ld_5", 1, 1, 0, 0, 0, 8'd5, 0, 8'd5);
        for (int i = 0; i < 3; i++) begin
            step("stall", 0, 0, 0, 1, 0, 8'd70, 0, 8'd5);
            chkf("stall_empty", bus.stk_empty, 1'b1);
        end
        step("stall_go", 1, 0, 0, 1, 0, 8'd70, 0, 8'd70);
        chkf("go_pushed", bus.stk_empty, 1'b0);
        step("go_ret", 1, 0, 0, 0, 1, 0, 0, 8'd6);
        chkf("go_empty", bus.stk_empty, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
